lsu: RTL and testbench

Load/store unit for the RV32I core's data path. It turns byte-addressed core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into accesses on the word-wide data RAM, which has a combinational read port and a write-enable. It sits between the execute stage and the data RAM:
- sub-word loads: lane extraction plus sign/zero extension;
- sub-word stores: read-modify-write;
- misaligned and out-of-range requests: reported on `rsp_err`.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu.sv | 161 ++++++++++++++++
 tb/tb_lsu.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and the
// FSM state type used by the top-level sequencer.
package lsu_pkg;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;
    localparam logic [1:0] LSU_SIZE_X = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RESP,
        ERR
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: extracts and extends
// sub-word load data and merges sub-word store data into an existing word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic [1:0]      lane,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] new_data,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/half, extend it for loads, splice it in for stores
    always_comb begin
        byte_sel   = old_word[{lane, 3'b000} +: 8];
        half_sel   = old_word[{lane[1], 4'b0000} +: 16];
        load_data  = '0;
        store_data = old_word;
        case (size)
            LSU_SIZE_B: begin
                if (is_unsigned)
                    load_data = {{(XLEN-8){1'b0}}, byte_sel};
                else
                    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
                store_data[{lane, 3'b000} +: 8] = new_data[7:0];
            end
            LSU_SIZE_H: begin
                if (is_unsigned)
                    load_data = {{(XLEN-16){1'b0}}, half_sel};
                else
                    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
                store_data[{lane[1], 4'b0000} +: 16] = new_data[15:0];
            end
            LSU_SIZE_W: begin
                load_data  = old_word;
                store_data = new_data;
            end
            default: begin
                load_data  = '0;
                store_data = old_word;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the execute stage and a word-wide data RAM with a
// combinational read port. Sub-word stores are done as read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses are rejected instead of being silently aligned.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_t state, next_state;

    logic            accept;
    logic            addr_oor;
    logic            misalign;
    logic            req_err;
    logic [1:0]      req_lane;

    logic            we_q;
    logic [1:0]      size_q;
    logic [1:0]      lane_q;
    logic            unsigned_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] store_data;

    assign accept   = req_valid && (state == IDLE);
    assign addr_oor = |req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == LSU_SIZE_H) && req_addr[0]) ||
                      ((req_size == LSU_SIZE_W) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = (req_size == LSU_SIZE_X) || addr_oor || misalign;

    // Force the lane to natural alignment so a misaligned access touches only its own word
    always_comb begin
        req_lane = req_addr[1:0];
        if (req_size == LSU_SIZE_H)
            req_lane[0] = 1'b0;
        else if (req_size == LSU_SIZE_W)
            req_lane = 2'b00;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state and handshake/response decode
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_err)
                        next_state = ERR;
                    else if (!req_we || (req_size != LSU_SIZE_W))
                        next_state = RD;
                    else
                        next_state = WR;
                end
            end
            RD: begin
                next_state = we_q ? WR : RESP;
            end
            WR: begin
                next_state = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                rsp_valid  = 1'b1;
                rsp_err    = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (unsigned_q),
        .old_word    (mem_rdata),
        .new_data    (wdata_q),
        .load_data   (load_data),
        .store_data  (store_data)
    );

    // Request capture, RAM-side registered outputs and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            size_q     <= LSU_SIZE_B;
            lane_q     <= 2'b00;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            mem_we <= (next_state == WR);
            if (accept && !req_err) begin
                we_q       <= req_we;
                size_q     <= req_size;
                lane_q     <= req_lane;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
                mem_addr   <= req_addr[ADDR_W+1:2];
                if (req_we && (req_size == LSU_SIZE_W))
                    mem_wdata <= req_wdata;
            end
            if (state == RD) begin
                rdata_q <= load_data;
                if (we_q)
                    mem_wdata <= store_data;
            end
        end
    end

    assign rsp_rdata = ((state == RESP) && !we_q) ? rdata_q : '0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for the load/store unit: table-driven requests with a
// response scoreboard, plus a hand-written reset-during-write sequence.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:4095];
    logic        pre_we;
    logic [11:0] pre_idx;
    logic [31:0] pre_val;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          rsp_cyc;
        int          we_cnt;
        int          we_cyc;
        logic [11:0] we_addr;
    } exp_t;

    typedef struct {
        int          pidx;
        logic [31:0] pval;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          exp_we;
        int          cidx;
        logic [31:0] cval;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    int          we_cnt = 0;
    int          we_cyc = 0;
    logic [11:0] we_addr = '0;

    lsu #(
        .ADDR_W (12),
        .XLEN   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data RAM model: combinational read, clocked write, bench preload port
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        else if (pre_we)
            ram[pre_idx] <= pre_val;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: tracks RAM write pulses and pops the scoreboard on each response
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (mem_we) begin
                we_cnt++;
                we_cyc  = cyc;
                we_addr = mem_addr;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                    checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    checkOutput("rsp_cycle", cyc, e.rsp_cyc);
                    checkOutput("mem_we_count", we_cnt, e.we_cnt);
                    if (e.we_cnt == 1) begin
                        checkOutput("mem_we_cycle", we_cyc, e.we_cyc);
                        checkOutput("mem_we_addr", {20'b0, we_addr}, {20'b0, e.we_addr});
                    end
                end
                we_cnt = 0;
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = idx[11:0];
        pre_val = val;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int n);
        exp_t e;
        int   c;
        int   waited;
        if (v.pidx >= 0)
            preload(v.pidx, v.pval);
        @(negedge clk);
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput($sformatf("req_ready_idle[%0d]", n), {31'b0, req_ready}, 32'd1);
        c            = cyc;
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        e.rdata      = v.exp_rdata;
        e.err        = v.exp_err;
        e.rsp_cyc    = c + v.lat;
        e.we_cnt     = v.exp_we;
        e.we_cyc     = c + v.lat - 1;
        e.we_addr    = v.addr[13:2];
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput($sformatf("req_ready_busy[%0d]", n), {31'b0, req_ready}, 32'd0);
        waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL rsp_timeout[%0d]: got no response expected one within 10 cycles", n);
            sb.delete();
        end
        if (v.cidx >= 0)
            checkOutput($sformatf("ram_word[%0d]", n), ram[v.cidx], v.cval);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        pre_we       = 1'b0;
        pre_idx      = '0;
        pre_val      = '0;

        //          pidx pval          we    size   uns   addr          wdata         exp_rdata     err   lat we cidx cval
        vecs.push_back('{4, 32'h87654321, 1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,        32'h87654321, 1'b0, 2, 0, -1, 32'h0});
        vecs.push_back('{4, 32'h80FF1234, 1'b0, 2'b00, 1'b0, 32'h00000013, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, -1, 32'h0});
        vecs.push_back('{-1, 32'h0,       1'b0, 2'b00, 1'b1, 32'h00000013, 32'h0,        32'h00000080, 1'b0, 2, 0, -1, 32'h0});
        vecs.push_back('{-1, 32'h0,       1'b0, 2'b01, 1'b0, 32'h00000012, 32'h0,        32'hFFFF80FF, 1'b0, 2, 0, -1, 32'h0});
        vecs.push_back('{-1, 32'h0,       1'b0, 2'b01, 1'b1, 32'h00000010, 32'h0,        32'h00001234, 1'b0, 2, 0, -1, 32'h0});
        vecs.push_back('{-1, 32'h0,       1'b0, 2'b00, 1'b0, 32'h00000011, 32'h0,        32'h00000012, 1'b0, 2, 0, -1, 32'h0});
        vecs.push_back('{4, 32'h11223344, 1'b1, 2'b00, 1'b0, 32'h00000011, 32'h000000AB, 32'h0,        1'b0, 3, 1, 4,  32'h1122AB44});
        vecs.push_back('{0, 32'h12345678, 1'b1, 2'b01, 1'b0, 32'h00000002, 32'h0000BEEF, 32'h0,        1'b0, 3, 1, 0,  32'hBEEF5678});
        vecs.push_back('{2, 32'h00000000, 1'b1, 2'b10, 1'b0, 32'h00000008, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1, 2,  32'hCAFEF00D});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{1, 32'hA5A55A5A, 1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0});
        vecs.push_back('{0, 32'h11111111, 1'b1, 2'b01, 1'b0, 32'h00000003, 32'h0000BEEF, 32'h0,        1'b1, 1, 0, 0,  32'h11111111});
`else
        vecs.push_back('{1, 32'hA5A55A5A, 1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0,        32'hA5A55A5A, 1'b0, 2, 0, -1, 32'h0});
        vecs.push_back('{0, 32'h11111111, 1'b1, 2'b01, 1'b0, 32'h00000003, 32'h0000BEEF, 32'h0,        1'b0, 3, 1, 0,  32'hBEEF1111});
`endif
        vecs.push_back('{-1, 32'h0,       1'b0, 2'b10, 1'b0, 32'h00004000, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0});
        vecs.push_back('{-1, 32'h0,       1'b0, 2'b11, 1'b0, 32'h00000000, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0});
        vecs.push_back('{3, 32'h0BADF00D, 1'b1, 2'b00, 1'b0, 32'h0001000C, 32'h000000FF, 32'h0,        1'b1, 1, 0, 3,  32'h0BADF00D});
        vecs.push_back('{7, 32'h00000000, 1'b1, 2'b00, 1'b0, 32'h0000001F, 32'h123456CD, 32'h0,        1'b0, 3, 1, 7,  32'hCD000000});

        // Reset values while rst_n is held low
        #12;
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("reset_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("reset_mem_addr", {20'b0, mem_addr}, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], i);

        // Reset asserted during the write cycle of a byte store
        preload(4, 32'h11223344);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h00000011;
        req_wdata    = 32'h000000AB;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_we_before", {31'b0, mem_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_we_after", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        we_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_mid_ready[%0d]", k), {31'b0, req_ready}, 32'd1);
            checkOutput($sformatf("rst_mid_no_rsp[%0d]", k), {31'b0, rsp_valid}, 32'd0);
        end
        checkOutput("rst_mid_ram_intact", ram[4], 32'h11223344);
        applyStimulus('{-1, 32'h0, 1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0, 32'h11223344, 1'b0, 2, 0, -1, 32'h0}, 99);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
